// File: rtl/fsm2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsm2_pkg
//  Purpose  : Shared state encoding and width for the fsm2 sequence detector.
//  Revision : 1.0 - initial release
// ============================================================================
package fsm2_pkg;

    localparam int W_STATE = 3;

    // Encoding is exported on c, so every code is pinned explicitly.
    typedef enum logic [W_STATE-1:0] {
        START     = 3'b000,
        S0        = 3'b001,
        S01       = 3'b010,
        S011      = 3'b011,
        S1        = 3'b100,
        S10       = 3'b101,
        S100      = 3'b110,
        ST_UNUSED = 3'b111
    } state_t;

endpackage : fsm2_pkg
`default_nettype wire

// File: rtl/fsm2_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsm2_if
//  Purpose  : Serial input and detect/debug outputs of the fsm2 detector.
//  Revision : 1.0 - initial release
// ============================================================================
interface fsm2_if;
    import fsm2_pkg::*;

    logic               s;
    logic               y1;
    logic               y2;
    logic [W_STATE-1:0] c;

    // Source of the serial stream; observes detection flags and state.
    modport master (
        output s,
        input  y1,
        input  y2,
        input  c
    );

    // The detector itself.
    modport slave (
        input  s,
        output y1,
        output y2,
        output c
    );

endinterface : fsm2_if
`default_nettype wire

// File: rtl/fsm2.sv
`default_nettype none
// ============================================================================
//  Module   : fsm2
//  Purpose  : Moore overlapping sequence detector; y1 flags "011", y2 flags
//             "100". The current state code is exported on c.
//  Revision : 1.0 - initial release
// ============================================================================
module fsm2
    import fsm2_pkg::*;
(
    input  wire logic ck,
    input  wire logic rs,
    fsm2_if.slave     bus
);

    state_t r_state;
    state_t w_next;

    // State register; reset takes priority over the serial input.
    always_ff @(posedge ck) begin
        if (rs) begin
            r_state <= START;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; each state remembers the longest useful suffix.
    always_comb begin
        w_next = START;
        case (r_state)
            START:   w_next = bus.s ? S1   : S0;
            S0:      w_next = bus.s ? S01  : S0;
            S01:     w_next = bus.s ? S011 : S10;
            S011:    w_next = bus.s ? S1   : S10;
            S1:      w_next = bus.s ? S1   : S10;
            S10:     w_next = bus.s ? S01  : S100;
            S100:    w_next = bus.s ? S01  : S0;
            default: w_next = START;   // unused code recovers unconditionally
        endcase
    end

    // Moore output decode straight from the state register.
    always_comb begin
        bus.y1 = 1'b0;
        bus.y2 = 1'b0;
        if (r_state == S011) begin
            bus.y1 = 1'b1;
        end
        if (r_state == S100) begin
            bus.y2 = 1'b1;
        end
    end

    assign bus.c = r_state;

endmodule : fsm2
`default_nettype wire

// File: tb/tb_fsm2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm2
//  Purpose  : Directed self-checking bench for the fsm2 sequence detector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm2;

    logic ck;
    logic rs;
    int   errors;
    int   checks;

    fsm2_if bus ();

    fsm2 dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input bit across one rising edge, then check the outputs.
    task automatic step(input logic r, input logic sv, input logic [2:0] ec,
                        input logic ey1, input logic ey2, input string tag);
        rs    = r;
        bus.s = sv;
        @(posedge ck);
        #1;
        check({tag, ".c"},  bus.c,          ec);
        check({tag, ".y1"}, {2'b00, bus.y1}, {2'b00, ey1});
        check({tag, ".y2"}, {2'b00, bus.y2}, {2'b00, ey2});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rs     = 1'b1;
        bus.s  = 1'b1;
        @(negedge ck);

        // Reset held with s=1, then release with s=1.
        step(1, 1, 3'b000, 0, 0, "rst0");
        step(1, 1, 3'b000, 0, 0, "rst1");
        step(0, 1, 3'b100, 0, 0, "rel_s1");

        // "011" detection.
        step(1, 0, 3'b000, 0, 0, "r_a");
        step(0, 0, 3'b001, 0, 0, "d011_0");
        step(0, 1, 3'b010, 0, 0, "d011_1");
        step(0, 1, 3'b011, 1, 0, "d011_2");

        // "100" detection.
        step(1, 0, 3'b000, 0, 0, "r_b");
        step(0, 1, 3'b100, 0, 0, "d100_0");
        step(0, 0, 3'b101, 0, 0, "d100_1");
        step(0, 0, 3'b110, 0, 1, "d100_2");

        // Overlap 0,1,1,0,0,1 then a long run of ones.
        step(1, 0, 3'b000, 0, 0, "r_c");
        step(0, 0, 3'b001, 0, 0, "ov0");
        step(0, 1, 3'b010, 0, 0, "ov1");
        step(0, 1, 3'b011, 1, 0, "ov2");
        step(0, 0, 3'b101, 0, 0, "ov3");
        step(0, 0, 3'b110, 0, 1, "ov4");
        step(0, 1, 3'b010, 0, 0, "ov5");
        step(0, 1, 3'b011, 1, 0, "run0");
        step(0, 1, 3'b100, 0, 0, "run1");
        step(0, 1, 3'b100, 0, 0, "run2");
        step(0, 1, 3'b100, 0, 0, "run3");

        // Idle zeros hold S0, then "11" completes "011".
        step(1, 0, 3'b000, 0, 0, "r_d");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 3'b001, 0, 0, "idle0");
        end
        // A glitch on s between edges must have no effect.
        #2 bus.s = 1'b1;
        #2 bus.s = 1'b0;
        step(0, 0, 3'b001, 0, 0, "glitch");
        step(0, 1, 3'b010, 0, 0, "idle_1a");
        step(0, 1, 3'b011, 1, 0, "idle_1b");

        // Reset mid-sequence from S10 discards history.
        step(1, 0, 3'b000, 0, 0, "r_e");
        step(0, 1, 3'b100, 0, 0, "mid0");
        step(0, 0, 3'b101, 0, 0, "mid1");
        step(1, 0, 3'b000, 0, 0, "mid_rst");
        step(0, 0, 3'b001, 0, 0, "mid_after");
        step(0, 0, 3'b001, 0, 0, "mid_after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fsm2
`default_nettype wire
